// File: rtl/bus_arbiter.sv
// Two-master (IF fetch, MA access) to one-slave TileLink-UL arbiter.
// MA has priority, IF is protected by a starvation streak limit, and clear squashes IF traffic.
module bus_arbiter #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,

    input  logic            if_request,
    input  logic            if_a_valid,
    output logic            if_a_ready,
    input  logic [2:0]      if_a_opcode,
    input  logic [2:0]      if_a_size,
    input  logic [AW-1:0]   if_a_address,
    input  logic [DW/8-1:0] if_a_mask,
    input  logic [DW-1:0]   if_a_data,
    output logic            if_d_valid,
    input  logic            if_d_ready,
    output logic [2:0]      if_d_opcode,
    output logic [DW-1:0]   if_d_data,

    input  logic            ma_request,
    input  logic            ma_a_valid,
    output logic            ma_a_ready,
    input  logic [2:0]      ma_a_opcode,
    input  logic [2:0]      ma_a_size,
    input  logic [AW-1:0]   ma_a_address,
    input  logic [DW/8-1:0] ma_a_mask,
    input  logic [DW-1:0]   ma_a_data,
    output logic            ma_d_valid,
    input  logic            ma_d_ready,
    output logic [2:0]      ma_d_opcode,
    output logic [DW-1:0]   ma_d_data,

    output logic            s_a_valid,
    input  logic            s_a_ready,
    output logic [2:0]      s_a_opcode,
    output logic [2:0]      s_a_size,
    output logic [AW-1:0]   s_a_address,
    output logic [DW/8-1:0] s_a_mask,
    output logic [DW-1:0]   s_a_data,
    input  logic            s_d_valid,
    output logic            s_d_ready,
    input  logic [2:0]      s_d_opcode,
    input  logic [DW-1:0]   s_d_data,

    output logic            grant_if,
    output logic            grant_ma
);

    // state | meaning
    // IDLE  | arbitrating on request lines
    // ADDR  | owner's A channel routed to the slave
    // DATA  | waiting for the owner's D beat
    // DROP  | swallowing a D beat owed to a squashed IF transaction
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    state_t     state_q, state_d;
    logic       owner_ma_q, owner_ma_d;
    logic [3:0] streak_q, streak_d;
    logic       grant_if_q, grant_if_d;
    logic       grant_ma_q, grant_ma_d;

    logic own_req, own_a_valid, own_d_ready, if_eff, a_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_ma_q <= 1'b0;
            streak_q   <= 4'd0;
            grant_if_q <= 1'b0;
            grant_ma_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_ma_q <= owner_ma_d;
            streak_q   <= streak_d;
            grant_if_q <= grant_if_d;
            grant_ma_q <= grant_ma_d;
        end
    end

    assign own_req     = owner_ma_q ? ma_request : if_request;
    assign own_a_valid = owner_ma_q ? ma_a_valid : if_a_valid;
    assign own_d_ready = owner_ma_q ? ma_d_ready : if_d_ready;
    assign if_eff      = if_request && !clear;
    assign a_fire      = own_a_valid && s_a_ready;

    // Payload fields follow the registered owner; only the valid/ready pairs are gated by state.
    assign s_a_opcode  = owner_ma_q ? ma_a_opcode  : if_a_opcode;
    assign s_a_size    = owner_ma_q ? ma_a_size    : if_a_size;
    assign s_a_address = owner_ma_q ? ma_a_address : if_a_address;
    assign s_a_mask    = owner_ma_q ? ma_a_mask    : if_a_mask;
    assign s_a_data    = owner_ma_q ? ma_a_data    : if_a_data;
    assign if_d_opcode = s_d_opcode;
    assign if_d_data   = s_d_data;
    assign ma_d_opcode = s_d_opcode;
    assign ma_d_data   = s_d_data;
    assign grant_if    = grant_if_q;
    assign grant_ma    = grant_ma_q;

    always_comb begin
        state_d    = state_q;
        owner_ma_d = owner_ma_q;
        streak_d   = streak_q;
        grant_if_d = grant_if_q;
        grant_ma_d = grant_ma_q;
        if_a_ready = 1'b0;
        ma_a_ready = 1'b0;
        if_d_valid = 1'b0;
        ma_d_valid = 1'b0;
        s_a_valid  = 1'b0;
        s_d_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ma_request && (!if_eff || streak_q < LIMIT)) begin
                    state_d    = ADDR;
                    owner_ma_d = 1'b1;
                    grant_ma_d = 1'b1;
                    if (!if_request)
                        streak_d = 4'd0;
                    else if (streak_q != 4'd15)
                        streak_d = streak_q + 4'd1;
                end else if (if_eff) begin
                    state_d    = ADDR;
                    owner_ma_d = 1'b0;
                    grant_if_d = 1'b1;
                    streak_d   = 4'd0;
                end
            end
            ADDR: begin
                s_a_valid = own_a_valid;
                if (!owner_ma_q && clear) begin
                    // The slave may still accept the beat; then its D response is owed.
                    state_d = a_fire ? DROP : IDLE;
                end else begin
                    if (owner_ma_q) ma_a_ready = s_a_ready;
                    else            if_a_ready = s_a_ready;
                    if (a_fire)
                        state_d = DATA;
                    else if (!own_req)
                        state_d = IDLE;
                end
            end
            DATA: begin
                if (!owner_ma_q && clear) begin
                    s_d_ready = 1'b1;
                    state_d   = s_d_valid ? IDLE : DROP;
                end else begin
                    s_d_ready = own_d_ready;
                    if (owner_ma_q) ma_d_valid = s_d_valid;
                    else            if_d_valid = s_d_valid;
                    if (s_d_valid && own_d_ready)
                        state_d = IDLE;
                end
            end
            DROP: begin
                s_d_ready = 1'b1;
                if (s_d_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            grant_if_d = 1'b0;
            grant_ma_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, latency, MA/IF priority with starvation limit,
// clear handling for IF and MA owners, and reset mid-transaction.
module tb_bus_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst, clear;
    logic            if_request, if_a_valid, if_a_ready, if_d_valid, if_d_ready;
    logic [2:0]      if_a_opcode, if_a_size, if_d_opcode;
    logic [AW-1:0]   if_a_address;
    logic [DW/8-1:0] if_a_mask;
    logic [DW-1:0]   if_a_data, if_d_data;
    logic            ma_request, ma_a_valid, ma_a_ready, ma_d_valid, ma_d_ready;
    logic [2:0]      ma_a_opcode, ma_a_size, ma_d_opcode;
    logic [AW-1:0]   ma_a_address;
    logic [DW/8-1:0] ma_a_mask;
    logic [DW-1:0]   ma_a_data, ma_d_data;
    logic            s_a_valid, s_a_ready, s_d_valid, s_d_ready;
    logic [2:0]      s_a_opcode, s_a_size, s_d_opcode;
    logic [AW-1:0]   s_a_address;
    logic [DW/8-1:0] s_a_mask;
    logic [DW-1:0]   s_a_data, s_d_data;
    logic            grant_if, grant_ma;

    int n_vec = 0;
    int n_err = 0;

    bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .if_request(if_request), .if_a_valid(if_a_valid), .if_a_ready(if_a_ready),
        .if_a_opcode(if_a_opcode), .if_a_size(if_a_size), .if_a_address(if_a_address),
        .if_a_mask(if_a_mask), .if_a_data(if_a_data), .if_d_valid(if_d_valid),
        .if_d_ready(if_d_ready), .if_d_opcode(if_d_opcode), .if_d_data(if_d_data),
        .ma_request(ma_request), .ma_a_valid(ma_a_valid), .ma_a_ready(ma_a_ready),
        .ma_a_opcode(ma_a_opcode), .ma_a_size(ma_a_size), .ma_a_address(ma_a_address),
        .ma_a_mask(ma_a_mask), .ma_a_data(ma_a_data), .ma_d_valid(ma_d_valid),
        .ma_d_ready(ma_d_ready), .ma_d_opcode(ma_d_opcode), .ma_d_data(ma_d_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_size(s_a_size), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
        .s_a_data(s_a_data), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
        .s_d_opcode(s_d_opcode), .s_d_data(s_d_data),
        .grant_if(grant_if), .grant_ma(grant_ma)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant_if"}, grant_if, 1'b0);
        check({tag, "_grant_ma"}, grant_ma, 1'b0);
        check({tag, "_if_a_ready"}, if_a_ready, 1'b0);
        check({tag, "_ma_a_ready"}, ma_a_ready, 1'b0);
        check({tag, "_if_d_valid"}, if_d_valid, 1'b0);
        check({tag, "_ma_d_valid"}, ma_d_valid, 1'b0);
        check({tag, "_s_a_valid"}, s_a_valid, 1'b0);
        check({tag, "_s_d_ready"}, s_d_ready, 1'b0);
        check({tag, "_streak"}, dut.streak_q, 4'd0);
    endtask

    bit exp_ma[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clear = 1'b0;
        if_request = 0; if_a_valid = 0; if_d_ready = 0; if_a_opcode = 3'd4; if_a_size = 3'd3;
        if_a_address = 64'h1000; if_a_mask = 8'hFF; if_a_data = '0;
        ma_request = 0; ma_a_valid = 0; ma_d_ready = 0; ma_a_opcode = 3'd4; ma_a_size = 3'd3;
        ma_a_address = 64'h2000; ma_a_mask = 8'hFF; ma_a_data = '0;
        s_a_ready = 0; s_d_valid = 0; s_d_opcode = 3'd1; s_d_data = '0;
        cyc(); cyc();
        check_reset_outputs("reset");
        rst = 1'b0;

        // MA-only read, zero-wait slave
        ma_request = 1; ma_a_valid = 1; ma_a_opcode = 3'd4; ma_a_address = 64'h8000_0000;
        ma_d_ready = 1; s_a_ready = 1;
        cyc();
        check("rd_grant_ma", grant_ma, 1'b1);
        check("rd_s_a_valid", s_a_valid, 1'b1);
        check("rd_s_a_addr", s_a_address, 64'h8000_0000);
        check("rd_ma_a_ready", ma_a_ready, 1'b1);
        cyc();
        s_d_valid = 1; s_d_opcode = 3'd1; s_d_data = 64'hDEAD_BEEF; #1;
        check("rd_ma_d_valid", ma_d_valid, 1'b1);
        check("rd_ma_d_data", ma_d_data, 64'hDEAD_BEEF);
        check("rd_s_d_ready", s_d_ready, 1'b1);
        cyc();
        s_d_valid = 0;
        check("rd_idle_grant", grant_ma, 1'b0);
        check("rd_idle_s_a_valid", s_a_valid, 1'b0);

        // Both masters hold request: MA x4, then IF, then MA again
        ma_request = 1; if_request = 1; if_a_valid = 1; if_d_ready = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("order_grant_ma", grant_ma, exp_ma[i]);
            check("order_grant_if", grant_if, !exp_ma[i]);
            cyc();
            s_d_valid = 1; s_d_data = 64'(i); #1;
            check("order_d_valid", exp_ma[i] ? ma_d_valid : if_d_valid, 1'b1);
            check("order_other_d", exp_ma[i] ? if_d_valid : ma_d_valid, 1'b0);
            cyc();
            s_d_valid = 0;
        end
        ma_request = 0; if_request = 0;

        // Clear before the IF A handshake, with MA waiting
        if_request = 1; if_a_valid = 1; s_a_ready = 0;
        cyc();
        check("clra_grant_if", grant_if, 1'b1);
        clear = 1; ma_request = 1; #1;
        check("clra_if_a_ready", if_a_ready, 1'b0);
        check("clra_ma_a_ready", ma_a_ready, 1'b0);
        cyc();
        clear = 0; #1;
        check("clra_idle_if", grant_if, 1'b0);
        check("clra_idle_ma", grant_ma, 1'b0);
        cyc();
        check("clra_ma_granted", grant_ma, 1'b1);
        s_a_ready = 1;
        cyc();
        s_d_valid = 1; #1;
        check("clra_ma_d_valid", ma_d_valid, 1'b1);
        cyc();
        s_d_valid = 0; ma_request = 0; if_request = 0;

        // Clear in DATA with IF owner
        if_request = 1; if_a_valid = 1; if_d_ready = 1; s_a_ready = 1;
        cyc();
        check("clrd_grant_if", grant_if, 1'b1);
        cyc();
        clear = 1; #1;
        check("clrd_data_s_d_ready", s_d_ready, 1'b1);
        check("clrd_data_if_d_valid", if_d_valid, 1'b0);
        cyc();
        clear = 0; if_request = 0; #1;
        check("clrd_drop_s_d_ready", s_d_ready, 1'b1);
        check("clrd_drop_grant", grant_if, 1'b1);
        cyc();
        s_d_valid = 1; #1;
        check("clrd_drop_if_d_valid", if_d_valid, 1'b0);
        check("clrd_drop_consume", s_d_ready, 1'b1);
        cyc();
        s_d_valid = 0; #1;
        check("clrd_idle_grant", grant_if, 1'b0);
        check("clrd_idle_s_d_ready", s_d_ready, 1'b0);

        // Clear during an MA PutFull
        ma_request = 1; ma_a_valid = 1; ma_a_opcode = 3'd0; ma_a_data = 64'h1122_3344_5566_7788;
        ma_d_ready = 1; s_a_ready = 1;
        cyc();
        clear = 1; #1;
        check("put_ma_a_ready", ma_a_ready, 1'b1);
        check("put_s_a_opcode", s_a_opcode, 3'd0);
        check("put_s_a_data", s_a_data, 64'h1122_3344_5566_7788);
        cyc();
        s_d_valid = 1; s_d_opcode = 3'd0; #1;
        check("put_ma_d_valid", ma_d_valid, 1'b1);
        check("put_ma_d_opcode", ma_d_opcode, 3'd0);
        check("put_s_d_ready", s_d_ready, 1'b1);
        cyc();
        s_d_valid = 0; clear = 0; ma_request = 0; #1;
        check("put_idle_grant", grant_ma, 1'b0);

        // Reset in the middle of DATA
        ma_request = 1; if_request = 1; ma_a_opcode = 3'd4;
        cyc();
        check("rst_grant_ma", grant_ma, 1'b1);
        cyc();
        check("rst_streak_pre", dut.streak_q, 4'd1);
        rst = 1; ma_request = 0; if_request = 0;
        cyc();
        rst = 0; #1;
        check_reset_outputs("rst_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
